tea_top: RTL and testbench

//   Iterative TEA (Tiny Encryption Algorithm, Wheeler & Needham 1994) block cipher core.

---
 rtl/tea_pkg.sv | 36 +++
 rtl/tea_round.sv | 51 +++++
 rtl/tea_top.sv | 154 +++++++++++++++
 tb/tb_tea_top.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
//   Shared constants, types and the TEA mixing function used by the iterative
//   TEA cipher core (tea_top) and its combinational round (tea_round).
// ---------------------------------------------------------------------------
package tea_pkg;

  // Key-schedule constant: floor(2^32 / golden ratio).
  localparam logic [31:0] DELTA            = 32'h9E3779B9;
  // Starting sum for decryption with the default round count (32 * DELTA mod 2^32).
  localparam logic [31:0] DEC_SUM_INIT     = 32'hC6EF3720;
  localparam int          ROUNDS_DEFAULT   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // One half-round mixing term: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb).
  // Shifts are logical and all additions wrap mod 2^32.
  function automatic logic [31:0] tea_mix(
    input logic [31:0] v,
    input logic [31:0] sum,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage : tea_pkg

// File: rtl/tea_round.sv
// ---------------------------------------------------------------------------
// tea_round
//   Purely combinational single TEA cycle (both half-rounds) in either
//   direction.
//   Ports:
//     mode_i      direction (MODE_ENC / MODE_DEC)
//     v0_i, v1_i  current block words
//     sum_i       current running sum
//     k0_i..k3_i  key words
//     v0_o, v1_o  block words after this cycle
//     sum_o       running sum after this cycle
// ---------------------------------------------------------------------------
module tea_round
  import tea_pkg::*;
(
  input  mode_e       mode_i,
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] sum_i,
  input  logic [31:0] k0_i,
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  output logic [31:0] v0_o,
  output logic [31:0] v1_o,
  output logic [31:0] sum_o
);

  logic [31:0] enc_sum;
  logic [31:0] enc_v0;
  logic [31:0] dec_v1;

  // Encrypt advances the sum before mixing; decrypt mixes with the current
  // sum and retreats it afterwards, and undoes the halves in reverse order.
  always_comb begin
    enc_sum = sum_i + DELTA;
    enc_v0  = v0_i + tea_mix(v1_i, enc_sum, k0_i, k1_i);
    dec_v1  = v1_i - tea_mix(v0_i, sum_i, k2_i, k3_i);

    if (mode_i == MODE_ENC) begin
      v0_o  = enc_v0;
      v1_o  = v1_i + tea_mix(enc_v0, enc_sum, k2_i, k3_i);
      sum_o = enc_sum;
    end else begin
      v1_o  = dec_v1;
      v0_o  = v0_i - tea_mix(dec_v1, sum_i, k0_i, k1_i);
      sum_o = sum_i - DELTA;
    end
  end

endmodule : tea_round

// File: rtl/tea_top.sv
// ---------------------------------------------------------------------------
// tea_top
//   Iterative TEA block cipher core, one full TEA cycle per clock.
//   A start in IDLE latches block, key and mode; ROUNDS cycles are run, then
//   the result is registered onto v0_out/v1_out with a one-cycle done pulse.
//   Ports:
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     start             request, sampled only in IDLE
//     mode              0 = encrypt, 1 = decrypt (latched with start)
//     v0_in, v1_in      input block (latched with start)
//     k0..k3            key words (latched with start)
//     v0_out, v1_out    registered result, held until the next completion
//     done              one-cycle completion pulse
// ---------------------------------------------------------------------------
module tea_top
  import tea_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] v0_in,
  input  logic [31:0] v1_in,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out,
  output logic        done
);

  localparam int               CntW    = $clog2(ROUNDS + 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(ROUNDS);
  // Decrypt starts from the sum encryption ends with: ROUNDS * DELTA mod 2^32.
  localparam logic [31:0]      SumInit = 32'(ROUNDS) * DELTA;

  state_e            state_q,  state_d;
  logic [CntW-1:0]   cnt_q,    cnt_d;
  mode_e             mode_q,   mode_d;
  logic [3:0][31:0]  key_q,    key_d;
  logic [31:0]       v0_q,     v0_d;
  logic [31:0]       v1_q,     v1_d;
  logic [31:0]       sum_q,    sum_d;
  logic [31:0]       v0_out_q, v0_out_d;
  logic [31:0]       v1_out_q, v1_out_d;
  logic              done_q,   done_d;

  logic [31:0]       rnd_v0, rnd_v1, rnd_sum;

  tea_round u_round (
    .mode_i (mode_q),
    .v0_i   (v0_q),
    .v1_i   (v1_q),
    .sum_i  (sum_q),
    .k0_i   (key_q[0]),
    .k1_i   (key_q[1]),
    .k2_i   (key_q[2]),
    .k3_i   (key_q[3]),
    .v0_o   (rnd_v0),
    .v1_o   (rnd_v1),
    .sum_o  (rnd_sum)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    key_d    = key_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    sum_d    = sum_q;
    v0_out_d = v0_out_q;
    v1_out_d = v1_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode_e'(mode);
          key_d   = {k3, k2, k1, k0};
          v0_d    = v0_in;
          v1_d    = v1_in;
          cnt_d   = '0;
          sum_d   = mode ? SumInit : 32'h0;
        end
      end

      RUN: begin
        // The counter reaching ROUNDS means all cycles are already applied;
        // this extra edge publishes the result.
        if (cnt_q == LastCnt) begin
          v0_out_d = v0_q;
          v1_out_d = v1_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          v0_d  = rnd_v0;
          v1_d  = rnd_v1;
          sum_d = rnd_sum;
          cnt_d = cnt_q + CntW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above. All registers,
  // including the latched key and working block, are cleared by reset so no
  // key material survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_ENC;
      key_q    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
      sum_q    <= '0;
      v0_out_q <= '0;
      v1_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      sum_q    <= sum_d;
      v0_out_q <= v0_out_d;
      v1_out_q <= v1_out_d;
      done_q   <= done_d;
    end
  end

  assign v0_out = v0_out_q;
  assign v1_out = v1_out_q;
  assign done   = done_q;

endmodule : tea_top

// File: tb/tb_tea_top.sv
// ---------------------------------------------------------------------------
// tb_tea_top
//   Self-checking bench for tea_top. Results are compared against a
//   behavioural TEA model written straight from the algorithm description.
// ---------------------------------------------------------------------------
module tb_tea_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] v0_in, v1_in;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] v0_out, v1_out;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected contents of the output registers between completions.
  logic [31:0] exp_out0 = 32'h0;
  logic [31:0] exp_out1 = 32'h0;

  tea_top dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .v0_in  (v0_in),
    .v1_in  (v1_in),
    .k0     (k0),
    .k1     (k1),
    .k2     (k2),
    .k3     (k3),
    .v0_out (v0_out),
    .v1_out (v1_out),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference TEA, 32 cycles, straight from the published algorithm.
  function automatic void tea_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ka, input logic [31:0] kb,
                                    input logic [31:0] kc, input logic [31:0] kd,
                                    output logic [31:0] r0, output logic [31:0] r1);
    logic [31:0] y, z, s, dl;
    dl = 32'h9E3779B9;
    y  = a;
    z  = b;
    s  = m ? 32'hC6EF3720 : 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (!m) begin
        s = s + dl;
        y = y + (((z << 4) + ka) ^ (z + s) ^ ((z >> 5) + kb));
        z = z + (((y << 4) + kc) ^ (y + s) ^ ((y >> 5) + kd));
      end else begin
        z = z - (((y << 4) + kc) ^ (y + s) ^ ((y >> 5) + kd));
        y = y - (((z << 4) + ka) ^ (z + s) ^ ((z >> 5) + kb));
        s = s - dl;
      end
    end
    r0 = y;
    r1 = z;
  endfunction

  // Called at a negedge. Presents one request, optionally scrambles inputs
  // and pulses start while the core is busy, and returns at the negedge of
  // the cycle following the done pulse (so the next call is back-to-back).
  task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ka, input logic [31:0] kb,
                       input logic [31:0] kc, input logic [31:0] kd,
                       input bit noisy,
                       output logic [31:0] r0, output logic [31:0] r1);
    logic [31:0] e0, e1;
    int lat;
    tea_model(m, a, b, ka, kb, kc, kd, e0, e1);
    mode  = m;
    v0_in = a;
    v1_in = b;
    k0 = ka; k1 = kb; k2 = kc; k3 = kd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        v0_in = $urandom; v1_in = $urandom;
        k0 = $urandom; k1 = $urandom; k2 = $urandom; k3 = $urandom;
      end
      @(negedge clk);
      lat++;
      if (done) break;
      check("out_hold_during_run", {v0_out, v1_out}, {exp_out0, exp_out1});
    end
    start = 1'b0;
    check("done_latency", 64'(lat), 64'd33);
    r0 = v0_out;
    r1 = v1_out;
    check("result_vs_model", {r0, r1}, {e0, e1});
    exp_out0 = e0;
    exp_out1 = e1;
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);
    check("out_stable_after_done", {v0_out, v1_out}, {exp_out0, exp_out1});
  endtask

  logic [31:0] c0, c1, p0, p1, d0, d1;
  logic [31:0] ra, rb, rk0, rk1, rk2, rk3;
  int pulses;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    v0_in = '0; v1_in = '0; k0 = '0; k1 = '0; k2 = '0; k3 = '0;
    repeat (3) @(negedge clk);
    check("rst_v0_out", {32'h0, v0_out}, 64'h0);
    check("rst_v1_out", {32'h0, v1_out}, 64'h0);
    check("rst_done",   {63'h0, done},   64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero vector, then decrypt it back (back-to-back start).
    do_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, c0, c1);
    check("zero_enc", {c0, c1}, {32'h41EA3A0A, 32'h94BAA940});
    do_op(1'b1, c0, c1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, d0, d1);
    check("zero_dec", {d0, d1}, 64'h0);

    // Round trip with noise on inputs and start during RUN.
    p0 = 32'h12345678; p1 = 32'h9ABCDEF0;
    do_op(1'b0, p0, p1, 32'h0A0B0C0D, 32'h0E0F1011, 32'h12131415, 32'h16171819, 1'b1, c0, c1);
    check("rt_cipher_differs", {63'h0, ({c0, c1} != {p0, p1})}, 64'h1);
    do_op(1'b1, c0, c1, 32'h0A0B0C0D, 32'h0E0F1011, 32'h12131415, 32'h16171819, 1'b1, d0, d1);
    check("rt_restore", {d0, d1}, {p0, p1});

    // All ones.
    do_op(1'b0, '1, '1, '1, '1, '1, '1, 1'b0, c0, c1);
    do_op(1'b1, c0, c1, '1, '1, '1, '1, 1'b0, d0, d1);
    check("ones_restore", {d0, d1}, 64'hFFFFFFFF_FFFFFFFF);

    // ASCII block.
    do_op(1'b0, 32'h48454C4C, 32'h4F212121, 32'hA56BABCD, 32'hEF012345, 32'h6789ABCD, 32'hEF012345, 1'b0, c0, c1);
    do_op(1'b1, c0, c1, 32'hA56BABCD, 32'hEF012345, 32'h6789ABCD, 32'hEF012345, 1'b0, d0, d1);
    check("ascii_restore", {d0, d1}, {32'h48454C4C, 32'h4F212121});

    // Key sensitivity.
    do_op(1'b0, p0, p1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, c0, c1);
    do_op(1'b0, p0, p1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, d0, d1);
    check("key_sensitivity", {63'h0, ({c0, c1} != {d0, d1})}, 64'h1);

    // Random blocks and keys, noisy inputs during RUN.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      rk0 = $urandom; rk1 = $urandom; rk2 = $urandom; rk3 = $urandom;
      do_op(1'b0, ra, rb, rk0, rk1, rk2, rk3, 1'b1, c0, c1);
      do_op(1'b1, c0, c1, rk0, rk1, rk2, rk3, 1'b1, d0, d1);
      check("rand_restore", {d0, d1}, {ra, rb});
    end

    // Reset in the middle of RUN: outputs cleared, no done pulse afterwards.
    mode = 1'b0; v0_in = p0; v1_in = p1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", {v0_out, v1_out}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_out0 = 32'h0;
    exp_out1 = 32'h0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'h0);
    check("midrst_out_held", {v0_out, v1_out}, 64'h0);

    // Core is idle again and accepts a fresh request.
    do_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, c0, c1);
    check("post_rst_zero_enc", {c0, c1}, {32'h41EA3A0A, 32'h94BAA940});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tea_top
